// File: rtl/enc_pkg.sv
// Shared types and constants for the LWE encryptor.
// Also holds the packing of message and noise into the final ciphertext entry.
package enc_pkg;

  localparam int PLAINTEXT_WIDTH    = 6;
  localparam int PLAINTEXT_MODULUS  = 64;
  localparam int CIPHERTEXT_WIDTH   = 10;
  localparam int CIPHERTEXT_MODULUS = 1024;
  localparam int DIMENSION          = 10;
  localparam int NOISE_WIDTH        = 4;
  localparam int ROW_WIDTH          = DIMENSION + 1;

  // Moduli must be powers of two so that mod reduces to truncation.
  localparam bit MODULI_OK =
    (PLAINTEXT_MODULUS == (32'd1 << PLAINTEXT_WIDTH)) &&
    (CIPHERTEXT_MODULUS == (32'd1 << CIPHERTEXT_WIDTH)) &&
    (PLAINTEXT_WIDTH + NOISE_WIDTH <= CIPHERTEXT_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  function automatic logic [CIPHERTEXT_WIDTH-1:0] embed_b(
    input logic [CIPHERTEXT_WIDTH-1:0] acc,
    input logic [PLAINTEXT_WIDTH-1:0]  m,
    input logic signed [NOISE_WIDTH-1:0] e
  );
    logic [CIPHERTEXT_WIDTH-1:0] m_ext;
    logic [CIPHERTEXT_WIDTH-1:0] e_ext;
    m_ext = {{(CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH){1'b0}}, m};
    e_ext = {{(CIPHERTEXT_WIDTH-NOISE_WIDTH){e[NOISE_WIDTH-1]}}, e} << PLAINTEXT_WIDTH;
    return acc + m_ext + e_ext;
  endfunction

endpackage

// File: rtl/mod_q_mac.sv
// Registered multiply-accumulate modulo 2**W with synchronous clear and enable.
module mod_q_mac #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod_s;
  logic [W-1:0] acc_r;

  assign prod_s = a * b;

  // accumulator register; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + prod_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/encrypt.sv
// Secret-key LWE encryptor: forwards each a_i, then emits b = <a,s> + m + p*e mod q.
// A single output register with pass-through on drain carries every ciphertext entry.
module encrypt
  import enc_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [PLAINTEXT_WIDTH-1:0]         plaintext,
  input  logic signed [NOISE_WIDTH-1:0]      noise,
  output logic                               busy,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0]        random_entry,
  input  logic [CIPHERTEXT_WIDTH-1:0]        secretkey_entry,
  output logic                               ct_valid,
  input  logic                               ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]        ciphertext_entry,
  output logic [ROW_WIDTH-1:0]               row,
  output logic                               done
);

  if (!MODULI_OK) begin : g_bad_moduli
    $error("encrypt: moduli are not consistent powers of two");
  end

  state_t                          state_r, state_s;
  logic [ROW_WIDTH-1:0]            cnt_r, cnt_s;
  logic [PLAINTEXT_WIDTH-1:0]      m_r, m_s;
  logic signed [NOISE_WIDTH-1:0]   e_r, e_s;
  logic                            ct_valid_r, ct_valid_s;
  logic [CIPHERTEXT_WIDTH-1:0]     entry_r, entry_s;
  logic [ROW_WIDTH-1:0]            row_r, row_s;
  logic [CIPHERTEXT_WIDTH-1:0]     acc_s;
  logic                            out_free_s;
  logic                            accept_s;
  logic                            mac_clr_s;

  assign out_free_s = !ct_valid_r || ct_ready;
  assign accept_s   = (state_r == ABSORB) && in_valid && out_free_s;
  assign mac_clr_s  = (state_r == IDLE) && start;

  mod_q_mac #(.W(CIPHERTEXT_WIDTH)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr_s),
    .en    (accept_s),
    .a     (random_entry),
    .b     (secretkey_entry),
    .acc   (acc_s)
  );

  // next-state and output-register next values
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    m_s        = m_r;
    e_s        = e_r;
    ct_valid_s = ct_valid_r;
    entry_s    = entry_r;
    row_s      = row_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          m_s     = plaintext;
          e_s     = noise;
          cnt_s   = {{(ROW_WIDTH-1){1'b0}}, 1'b1};
          state_s = ABSORB;
        end else begin
          state_s = IDLE;
        end
      end
      ABSORB: begin
        if (accept_s) begin
          entry_s    = random_entry;
          row_s      = cnt_r;
          ct_valid_s = 1'b1;
          cnt_s      = cnt_r + {{(ROW_WIDTH-1){1'b0}}, 1'b1};
          if (cnt_r == ROW_WIDTH'(DIMENSION)) begin
            state_s = FINAL;
          end else begin
            state_s = ABSORB;
          end
        end else if (ct_ready) begin
          ct_valid_s = 1'b0;
        end else begin
          ct_valid_s = ct_valid_r;
        end
      end
      FINAL: begin
        if (out_free_s) begin
          entry_s    = embed_b(acc_s, m_r, e_r);
          row_s      = ROW_WIDTH'(DIMENSION + 1);
          ct_valid_s = 1'b1;
          state_s    = DRAIN;
        end else begin
          state_s = FINAL;
        end
      end
      DRAIN: begin
        if (ct_valid_r && ct_ready) begin
          ct_valid_s = 1'b0;
          state_s    = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s    = IDLE;
        ct_valid_s = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      m_r        <= '0;
      e_r        <= '0;
      ct_valid_r <= 1'b0;
      entry_r    <= '0;
      row_r      <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      m_r        <= m_s;
      e_r        <= e_s;
      ct_valid_r <= ct_valid_s;
      entry_r    <= entry_s;
      row_r      <= row_s;
    end
  end

  // done marks the downstream acceptance of b itself, so it is a handshake term
  assign done             = (state_r == DRAIN) && ct_valid_r && ct_ready;
  assign busy             = (state_r != IDLE);
  assign in_ready         = (state_r == ABSORB) && out_free_s;
  assign ct_valid         = ct_valid_r;
  assign ciphertext_entry = entry_r;
  assign row              = row_r;

endmodule

// File: tb/tb_encrypt.sv
// Directed and table-driven bench for the LWE encryptor, with a random round-trip sweep.
module tb_encrypt;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  plaintext;
  logic signed [3:0] noise;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  random_entry;
  logic [9:0]  secretkey_entry;
  logic        ct_valid;
  logic        ct_ready;
  logic [9:0]  ciphertext_entry;
  logic [10:0] row;
  logic        done;

  encrypt dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .plaintext        (plaintext),
    .noise            (noise),
    .busy             (busy),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .random_entry     (random_entry),
    .secretkey_entry  (secretkey_entry),
    .ct_valid         (ct_valid),
    .ct_ready         (ct_ready),
    .ciphertext_entry (ciphertext_entry),
    .row              (row),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] a_v [10];
  logic [9:0] s_v [10];

  typedef struct {
    logic [5:0]        m;
    logic signed [3:0] e;
    logic [9:0]        a;
    logic [9:0]        s;
    int                rmode;
    int                vmode;
    bit                hold;
    logic [9:0]        exp_b;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // rmode: 0 ready always, 1 stall 3 cycles on row 4, 2 random; vmode: 0 always, 1 every other cycle, 2 random
  task automatic run_msg(input string tag, input logic [5:0] m, input logic signed [3:0] e,
                         input int rmode, input int vmode, input bit hold, input logic [9:0] exp_b);
    int k = 0;
    int n_out = 0;
    int cyc = 0;
    int stall = 0;
    int ri;
    int sum = 0;
    bit fin = 1'b0;
    bit prev_hold = 1'b0;
    logic [9:0]  prev_e = 10'd0;
    logic [10:0] prev_r = 11'd0;
    logic [9:0]  got_b = 10'd0;
    for (int i = 0; i < 10; i++) sum += int'(a_v[i]) * int'(s_v[i]);
    @(posedge clk); #1;
    start = 1'b1; plaintext = m; noise = e; in_valid = 1'b0; ct_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_after_start"}, busy, 1);
    while (!fin && cyc < 400) begin
      start = hold;
      in_valid = (k < 10) && ((vmode == 0) || (vmode == 1 && cyc % 2 == 0) ||
                              (vmode == 2 && $urandom_range(1, 0) == 1));
      random_entry    = a_v[(k < 10) ? k : 9];
      secretkey_entry = s_v[(k < 10) ? k : 9];
      if (rmode == 1 && ct_valid && row == 11'd4 && stall < 3) begin
        ct_ready = 1'b0;
        stall++;
      end else if (rmode == 2) begin
        ct_ready = ($urandom_range(1, 0) == 1);
      end else begin
        ct_ready = 1'b1;
      end
      #1;
      if (prev_hold) begin
        check({tag, "_hold_valid"}, ct_valid, 1);
        check({tag, "_hold_entry"}, ciphertext_entry, prev_e);
        check({tag, "_hold_row"}, row, prev_r);
      end
      if (rmode == 1 && !ct_ready) check({tag, "_stall_in_ready"}, in_ready, 0);
      if (ct_valid && ct_ready) begin
        ri = int'(row);
        check({tag, "_row_seq"}, ri, n_out + 1);
        if (ri >= 1 && ri <= 10) check({tag, "_a_entry"}, ciphertext_entry, a_v[ri-1]);
        if (ri == 11) got_b = ciphertext_entry;
        n_out++;
      end
      if (done) begin
        check({tag, "_done_at_b"}, n_out, 11);
        fin = 1'b1;
      end
      if (in_valid && in_ready) k++;
      prev_hold = ct_valid && !ct_ready;
      prev_e = ciphertext_entry;
      prev_r = row;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    check({tag, "_finished_in_budget"}, fin, 1);
    check({tag, "_beats_out"}, n_out, 11);
    check({tag, "_b"}, got_b, exp_b);
    check({tag, "_roundtrip_m"}, (int'(got_b) - sum) & 63, m);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_ct_valid_low"}, ct_valid, 0);
    if (rmode == 0 && vmode == 0) check({tag, "_latency"}, cyc, 12);
    @(posedge clk); #1;
    check({tag, "_no_second_msg"}, busy, 0);
  endtask

  initial begin
    int seen;
    int cyc;
    int ei;
    int sum;
    int expb;
    logic [5:0] mr;
    logic signed [3:0] er;

    tbl[0] = '{6'd5,  4'sd0,    10'd1,    10'd1,    0, 0, 1'b0, 10'd15};
    tbl[1] = '{6'd5,  4'sb1111, 10'd1,    10'd1,    0, 0, 1'b0, 10'd975};
    tbl[2] = '{6'd0,  4'sd0,    10'd1023, 10'd1023, 0, 0, 1'b0, 10'd10};
    tbl[3] = '{6'd63, 4'sd7,    10'd1023, 10'd1023, 0, 0, 1'b0, 10'd521};
    tbl[4] = '{6'd5,  4'sd0,    10'd1,    10'd1,    1, 0, 1'b0, 10'd15};
    tbl[5] = '{6'd2,  4'sb1000, 10'd3,    10'd5,    0, 1, 1'b0, 10'd664};
    tbl[6] = '{6'd9,  4'sd3,    10'd2,    10'd7,    0, 0, 1'b1, 10'd341};
    tbl[7] = '{6'd0,  4'sd0,    10'd100,  10'd20,   0, 0, 1'b0, 10'd544};

    rst_n = 1'b0; start = 1'b0; plaintext = 6'd0; noise = 4'sd0;
    in_valid = 1'b0; random_entry = 10'd0; secretkey_entry = 10'd0; ct_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_ct_valid", ct_valid, 0);
    check("reset_done", done, 0);
    check("reset_row", row, 0);
    check("reset_entry", ciphertext_entry, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 10; i++) begin
        a_v[i] = tbl[v].a;
        s_v[i] = tbl[v].s;
      end
      run_msg($sformatf("vec%0d", v), tbl[v].m, tbl[v].e, tbl[v].rmode, tbl[v].vmode,
              tbl[v].hold, tbl[v].exp_b);
    end

    // reset in the middle of a message
    for (int i = 0; i < 10; i++) begin
      a_v[i] = 10'd1;
      s_v[i] = 10'd1;
    end
    @(posedge clk); #1;
    start = 1'b1; plaintext = 6'd7; noise = 4'sd0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (seen == 0 && cyc < 100) begin
      in_valid = 1'b1; random_entry = 10'd1; secretkey_entry = 10'd1; ct_ready = 1'b1;
      #1;
      if (ct_valid && ct_ready && row == 11'd6) seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst_row6_seen", seen, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("midrst_ct_valid", ct_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_row", row, 0);
    check("midrst_entry", ciphertext_entry, 0);
    @(posedge clk); #1;
    check("midrst_stays_idle", ct_valid, 0);
    run_msg("after_rst", 6'd1, 4'sd0, 0, 0, 1'b0, 10'd11);

    // random round trips
    for (int r = 0; r < 200; r++) begin
      sum = 0;
      for (int i = 0; i < 10; i++) begin
        a_v[i] = 10'($urandom_range(1023, 0));
        s_v[i] = 10'($urandom_range(1023, 0));
        sum += int'(a_v[i]) * int'(s_v[i]);
      end
      mr = 6'($urandom_range(63, 0));
      ei = int'($urandom_range(14, 0)) - 7;
      er = 4'(ei);
      expb = ((sum + int'(mr) + ei * 64) % 1024 + 1024) % 1024;
      run_msg($sformatf("rnd%0d", r), mr, er, ($urandom_range(1, 0) == 1) ? 2 : 0,
              ($urandom_range(1, 0) == 1) ? 2 : 0, ($urandom_range(1, 0) == 1), 10'(expb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
